// File: rtl/ifetch_redirect.sv
// ifetch_redirect: parametrised instruction-fetch stage.
// It drives a 1-cycle-latency synchronous instruction memory and presents
// {pc_out, instruction, valid_out, fault_out} to the decode pipeline register.
// A redirect squashes the word in flight and leaves a one-cycle bubble.
// A stall freezes the presented word. Fetches outside the memory range
// are tagged as faults, and the stream keeps flowing.
module ifetch_redirect #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_AWIDTH = 9,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic [IMEM_AWIDTH-1:0] imem_addr,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            pc_out,
  output logic [31:0]            instruction,
  output logic                   valid_out,
  output logic                   fault_out
);

  // Address currently presented to the instruction memory.
  logic [31:0] fetch_pc;
  // PC and validity of the word arriving on imem_rdata this cycle.
  logic [31:0] resp_pc;
  logic        resp_valid;
  // Word captured on the first stall cycle. While stalled, the memory keeps
  // re-reading fetch_pc, so imem_rdata no longer matches resp_pc.
  logic [31:0] hold_instr;
  logic        hold_valid;
  // Set when resp_pc lies above the implemented memory.
  logic        out_of_range;

  assign imem_addr = fetch_pc[IMEM_AWIDTH+1:2];
  assign pc_out    = resp_pc;
  assign valid_out = resp_valid;
  assign fault_out = resp_valid & out_of_range;

  // A 30-bit word address spans the whole 32-bit space, so nothing can fault.
  generate
    if (IMEM_AWIDTH >= 30) begin : g_no_fault
      assign out_of_range = 1'b0;
    end else begin : g_fault
      assign out_of_range = |resp_pc[31:IMEM_AWIDTH+2];
    end
  endgenerate

  // Select the presented word: bubble/fault -> NOP, else held word, else memory data.
  always_comb begin
    instruction = imem_rdata;
    if (!resp_valid || fault_out) begin
      instruction = NOP_INSTR;
    end else if (hold_valid) begin
      instruction = hold_instr;
    end
  end

  // Fetch state update, priority: reset > redirect > stall > advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      resp_pc    <= RESET_PC;
      resp_valid <= 1'b0;
      hold_valid <= 1'b0;
      hold_instr <= NOP_INSTR;
    end else if (redirect_valid) begin
      fetch_pc   <= redirect_pc & 32'hFFFF_FFFC;
      resp_valid <= 1'b0;
      hold_valid <= 1'b0;
    end else if (stall) begin
      if (!hold_valid) begin
        hold_instr <= instruction;
        hold_valid <= 1'b1;
      end
    end else begin
      fetch_pc   <= fetch_pc + 32'd4;
      resp_pc    <= fetch_pc;
      resp_valid <= 1'b1;
      hold_valid <= 1'b0;
    end
  end

endmodule
